interrupt_sequencer: RTL and testbench

- Decides at each instruction boundary whether to take a maskable or non-maskable interrupt, and sequences the acknowledge cycle.
- Owns IFF1, IFF2, the interrupt mode, the EI shadow and the NMI edge latch. Replaces the scattered per-flag flip-flop wiring in the control block.
- Hands the core a PC-push request and a 16-bit jump vector, which the core uses to enter the service routine.

---
 rtl/interrupt_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: owns IFF1/IFF2, interrupt mode, EI shadow and NMI latch,
// decides acceptance at instruction boundaries and runs the acknowledge cycle.
module interrupt_sequencer #(
  parameter int unsigned INTA_TSTATES = 6,
  parameter int unsigned NMI_TSTATES  = 5,
  parameter logic [15:0] NMI_VECTOR   = 16'h0066,
  parameter logic [15:0] IM1_VECTOR   = 16'h0038
) (
  input  logic        Clk,
  input  logic        notReset,
  input  logic        INT,
  input  logic        NMI,
  input  logic        InstrEnd,
  input  logic        Op_EI,
  input  logic        Op_DI,
  input  logic        Op_RETN,
  input  logic        Op_IM,
  input  logic [1:0]  IM_Sel,
  input  logic [7:0]  I_Reg,
  input  logic [7:0]  VecByte,
  input  logic        PushDone,
  input  logic        TblDone,
  input  logic [15:0] TblData,
  input  logic        HaltState,
  output logic        IFF1,
  output logic        IFF2,
  output logic [1:0]  IM,
  output logic        AckActive,
  output logic        notINTA,
  output logic        PushReq,
  output logic        TblReq,
  output logic [15:0] TblAddr,
  output logic [15:0] Vector,
  output logic        VectorValid,
  output logic        HaltExit
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] INTA_LAST = CNT_W'(INTA_TSTATES);
  localparam logic [CNT_W-1:0] NMI_LAST  = CNT_W'(NMI_TSTATES);

  typedef enum logic [2:0] {
    S_IDLE, S_NMI_ACK, S_INT_ACK, S_PUSH, S_TBL, S_VECTOR
  } state_e;

  // Source of the interrupt being serviced; IM values map 1:1 onto the low codes.
  typedef enum logic [1:0] {
    KIND_IM0 = 2'd0, KIND_IM1 = 2'd1, KIND_IM2 = 2'd2, KIND_NMI = 2'd3
  } kind_e;

  state_e           state_q;
  kind_e            kind_q;
  logic [CNT_W-1:0] cnt_q;
  logic             iff1_q, iff2_q, shadow_q, nmi_prev_q, nmi_latch_q;
  logic [1:0]       im_q;
  logic [7:0]       vec_byte_q;
  logic             ack_q, ninta_q, push_req_q, tbl_req_q, vv_q, halt_exit_q;
  logic [15:0]      tbl_addr_q, vector_q;

  logic             iff1_d, iff2_d, shadow_d;
  logic [1:0]       im_d;
  logic             boundary, nmi_edge, nmi_pend, take_nmi, take_int, rst_byte;
  logic [15:0]      im0_vector;
  logic [15:0]      direct_vector;

  assign IFF1        = iff1_q;
  assign IFF2        = iff2_q;
  assign IM          = im_q;
  assign AckActive   = ack_q;
  assign notINTA     = ninta_q;
  assign PushReq     = push_req_q;
  assign TblReq      = tbl_req_q;
  assign TblAddr     = tbl_addr_q;
  assign Vector      = vector_q;
  assign VectorValid = vv_q;
  assign HaltExit    = halt_exit_q;

  assign boundary = (state_q == S_IDLE) & InstrEnd;
  assign nmi_edge = NMI & ~nmi_prev_q;
  // An edge arriving on the boundary cycle itself is taken immediately.
  assign nmi_pend = nmi_latch_q | nmi_edge;
  assign take_nmi = boundary & nmi_pend;
  assign take_int = boundary & ~nmi_pend & INT & iff1_d & ~shadow_d;

  assign rst_byte   = (&vec_byte_q[7:6]) & (&vec_byte_q[2:0]);
  assign im0_vector = rst_byte ? {10'b0, vec_byte_q[5:3], 3'b000} : IM1_VECTOR;

  // Instruction-end flag updates; acceptance looks at these updated values.
  always_comb begin
    iff1_d   = iff1_q;
    iff2_d   = iff2_q;
    shadow_d = shadow_q;
    im_d     = im_q;
    if (boundary) begin
      shadow_d = Op_EI & ~Op_DI;
      if (Op_DI) begin
        iff1_d = 1'b0;
        iff2_d = 1'b0;
      end else if (Op_EI) begin
        iff1_d = 1'b1;
        iff2_d = 1'b1;
      end else if (Op_RETN) begin
        iff1_d = iff2_q;
      end
      if (Op_IM) im_d = (IM_Sel == 2'd3) ? 2'd0 : IM_Sel;
    end
  end

  // Jump target for every source that does not need the IM2 table read.
  always_comb begin
    direct_vector = IM1_VECTOR;
    case (kind_q)
      KIND_NMI: direct_vector = NMI_VECTOR;
      KIND_IM0: direct_vector = im0_vector;
      default:  direct_vector = IM1_VECTOR;
    endcase
  end

  // Flags, NMI edge latch and acknowledge sequence with registered outputs.
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      state_q     <= S_IDLE;
      kind_q      <= KIND_IM0;
      cnt_q       <= '0;
      iff1_q      <= 1'b0;
      iff2_q      <= 1'b0;
      shadow_q    <= 1'b0;
      nmi_prev_q  <= 1'b0;
      nmi_latch_q <= 1'b0;
      im_q        <= 2'd0;
      vec_byte_q  <= 8'h00;
      ack_q       <= 1'b0;
      ninta_q     <= 1'b1;
      push_req_q  <= 1'b0;
      tbl_req_q   <= 1'b0;
      vv_q        <= 1'b0;
      halt_exit_q <= 1'b0;
      tbl_addr_q  <= 16'h0000;
      vector_q    <= 16'h0000;
    end else begin
      nmi_prev_q  <= NMI;
      iff1_q      <= iff1_d;
      iff2_q      <= iff2_d;
      shadow_q    <= shadow_d;
      im_q        <= im_d;
      halt_exit_q <= 1'b0;
      vv_q        <= 1'b0;
      if (take_nmi)      nmi_latch_q <= 1'b0;
      else if (nmi_edge) nmi_latch_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (take_nmi) begin
            iff2_q      <= iff1_d;
            iff1_q      <= 1'b0;
            kind_q      <= KIND_NMI;
            cnt_q       <= CNT_W'(1);
            ack_q       <= 1'b1;
            halt_exit_q <= HaltState;
            state_q     <= S_NMI_ACK;
          end else if (take_int) begin
            iff1_q      <= 1'b0;
            iff2_q      <= 1'b0;
            kind_q      <= kind_e'(im_d);
            cnt_q       <= CNT_W'(1);
            ack_q       <= 1'b1;
            halt_exit_q <= HaltState;
            state_q     <= S_INT_ACK;
          end
        end
        S_NMI_ACK: begin
          if (cnt_q == NMI_LAST) begin
            push_req_q <= 1'b1;
            state_q    <= S_PUSH;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_INT_ACK: begin
          if (cnt_q == CNT_W'(4)) vec_byte_q <= VecByte;
          if (cnt_q == INTA_LAST) begin
            ninta_q    <= 1'b1;
            push_req_q <= 1'b1;
            state_q    <= S_PUSH;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            ninta_q <= ~((cnt_q == CNT_W'(2)) | (cnt_q == CNT_W'(3)));
          end
        end
        S_PUSH: begin
          if (PushDone) begin
            push_req_q <= 1'b0;
            if (kind_q == KIND_IM2) begin
              tbl_req_q  <= 1'b1;
              tbl_addr_q <= {I_Reg, vec_byte_q[7:1], 1'b0};
              state_q    <= S_TBL;
            end else begin
              vector_q <= direct_vector;
              vv_q     <= 1'b1;
              state_q  <= S_VECTOR;
            end
          end
        end
        S_TBL: begin
          if (TblDone) begin
            tbl_req_q <= 1'b0;
            vector_q  <= TblData;
            vv_q      <= 1'b1;
            state_q   <= S_VECTOR;
          end
        end
        S_VECTOR: begin
          ack_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_interrupt_sequencer;

  localparam int INTA_T = 6;
  localparam int NMI_T  = 5;

  logic        Clk = 1'b0, notReset = 1'b0;
  logic        INT = 1'b0, NMI = 1'b0, InstrEnd = 1'b0;
  logic        Op_EI = 1'b0, Op_DI = 1'b0, Op_RETN = 1'b0, Op_IM = 1'b0;
  logic [1:0]  IM_Sel = 2'd0;
  logic [7:0]  I_Reg = 8'h00, VecByte = 8'h00;
  logic        PushDone = 1'b0, TblDone = 1'b0, HaltState = 1'b0;
  logic [15:0] TblData = 16'h0000;
  logic        IFF1, IFF2, AckActive, notINTA, PushReq, TblReq, VectorValid, HaltExit;
  logic [1:0]  IM;
  logic [15:0] TblAddr, Vector;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: architectural flags and pending NMI.
  bit m_iff1, m_iff2, m_shadow, m_nmi_prev, m_nmi_pend;
  int m_im;

  interrupt_sequencer dut (
    .Clk(Clk), .notReset(notReset), .INT(INT), .NMI(NMI), .InstrEnd(InstrEnd),
    .Op_EI(Op_EI), .Op_DI(Op_DI), .Op_RETN(Op_RETN), .Op_IM(Op_IM), .IM_Sel(IM_Sel),
    .I_Reg(I_Reg), .VecByte(VecByte), .PushDone(PushDone), .TblDone(TblDone),
    .TblData(TblData), .HaltState(HaltState), .IFF1(IFF1), .IFF2(IFF2), .IM(IM),
    .AckActive(AckActive), .notINTA(notINTA), .PushReq(PushReq), .TblReq(TblReq),
    .TblAddr(TblAddr), .Vector(Vector), .VectorValid(VectorValid), .HaltExit(HaltExit)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_iff1 = 0; m_iff2 = 0; m_shadow = 0; m_nmi_prev = 0; m_nmi_pend = 0; m_im = 0;
  endtask

  task automatic set_nmi(input logic v);
    if (v && !m_nmi_prev) m_nmi_pend = 1;
    m_nmi_prev = v;
    NMI = v;
  endtask

  function automatic logic [15:0] im0_vec(input logic [7:0] b);
    if (b[7:6] == 2'b11 && b[2:0] == 3'b111) return {10'b0, b[5:3], 3'b000};
    return 16'h0038;
  endfunction

  task automatic check_reset_outputs();
    check("rst_iff1", IFF1, 0);          check("rst_iff2", IFF2, 0);
    check("rst_im", IM, 0);              check("rst_ack", AckActive, 0);
    check("rst_ninta", notINTA, 1);      check("rst_push", PushReq, 0);
    check("rst_tblreq", TblReq, 0);      check("rst_tbladdr", TblAddr, 0);
    check("rst_vector", Vector, 0);      check("rst_vv", VectorValid, 0);
    check("rst_haltexit", HaltExit, 0);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge Clk);
      check("gap_ack", AckActive, 0);
    end
  endtask

  // Drives the core's side of an acknowledge sequence and checks its shape.
  task automatic run_ack(input int kind, input logic [7:0] vb, input logic [15:0] tdata,
                         input int nmi_at);
    logic [15:0] exp_vec;
    int cyc = 1, low_cnt = 0, low_first = 0, push_at = 0, extra_hx = 0, ack_drop = 0;
    int pd_wait = int'($urandom_range(0, 3));
    int td_wait = int'($urandom_range(0, 3));
    bit done = 0, tbl_seen = 0;
    exp_vec = (kind == 3) ? 16'h0066 : (kind == 1) ? 16'h0038 :
              (kind == 2) ? tdata : im0_vec(vb);
    VecByte = 8'($urandom);
    while (!done && cyc <= 40) begin
      if (cyc == nmi_at) set_nmi(!NMI);
      if (!notINTA) begin
        if (low_cnt == 0) low_first = cyc;
        low_cnt++;
        VecByte = vb;
      end else begin
        VecByte = 8'($urandom);
      end
      if (HaltExit && cyc > 1) extra_hx++;
      if (!AckActive) ack_drop++;
      if (PushReq) begin
        if (push_at == 0) push_at = cyc;
        if (pd_wait == 0) PushDone = 1'b1;
        else begin pd_wait--; PushDone = 1'b0; end
      end else PushDone = 1'b0;
      if (TblReq) begin
        if (!tbl_seen) begin
          tbl_seen = 1;
          check("tbl_addr", TblAddr, {I_Reg, vb[7:1], 1'b0});
        end
        if (td_wait == 0) begin TblDone = 1'b1; TblData = tdata; end
        else begin td_wait--; TblDone = 1'b0; TblData = 16'($urandom); end
      end else TblDone = 1'b0;
      if (VectorValid) begin
        done = 1;
        check("vector", Vector, exp_vec);
      end else begin
        @(negedge Clk);
        cyc++;
      end
    end
    check("ack_timeout", done, 1);
    check("inta_low_cycles", low_cnt, (kind == 3) ? 0 : 2);
    check("inta_low_first", low_first, (kind == 3) ? 0 : 3);
    check("push_start", push_at, ((kind == 3) ? NMI_T : INTA_T) + 1);
    check("haltexit_extra", extra_hx, 0);
    check("ack_held", ack_drop, 0);
    check("tbl_used", tbl_seen, kind == 2);
    @(negedge Clk);
    PushDone = 1'b0; TblDone = 1'b0;
    check("vv_one_cycle", VectorValid, 0);
    check("ack_release", AckActive, 0);
  endtask

  // Reset hits while the sequencer waits in PUSH.
  task automatic abort_seq();
    int k = 0;
    while (!PushReq && k < 20) begin @(negedge Clk); k++; end
    check("abort_in_push", PushReq, 1);
    #2 notReset = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge Clk); @(negedge Clk);
    notReset = 1'b1;
    repeat (8) begin
      @(negedge Clk);
      check("abort_no_vv", VectorValid, 0);
      check("abort_no_ack", AckActive, 0);
    end
  endtask

  // One instruction boundary: model prediction, then flag and acceptance checks.
  task automatic instr(input bit ei, input bit di, input bit retn, input bit imop,
                       input logic [1:0] imsel, input bit intv, input bit halt,
                       input logic [7:0] vb, input logic [15:0] tdata,
                       input int nmi_at, input bit abort);
    bit tn, ti;
    int kind;
    InstrEnd = 1'b1; Op_EI = ei; Op_DI = di; Op_RETN = retn; Op_IM = imop;
    IM_Sel = imsel; INT = intv; HaltState = halt;
    if (di) begin m_iff1 = 0; m_iff2 = 0; end
    else if (ei) begin m_iff1 = 1; m_iff2 = 1; end
    else if (retn) m_iff1 = m_iff2;
    if (imop) m_im = (imsel == 2'd3) ? 0 : int'(imsel);
    m_shadow = ei && !di;
    tn = m_nmi_pend;
    ti = !tn && intv && m_iff1 && !m_shadow;
    if (tn) begin m_iff2 = m_iff1; m_iff1 = 0; m_nmi_pend = 0; end
    else if (ti) begin m_iff1 = 0; m_iff2 = 0; end
    kind = tn ? 3 : m_im;
    @(negedge Clk);
    InstrEnd = 1'b0; Op_EI = 1'b0; Op_DI = 1'b0; Op_RETN = 1'b0; Op_IM = 1'b0;
    HaltState = 1'b0;
    check("iff1", IFF1, m_iff1);
    check("iff2", IFF2, m_iff2);
    check("im", IM, m_im);
    check("accept", AckActive, tn | ti);
    check("haltexit", HaltExit, (tn | ti) & halt);
    if (tn | ti) begin
      if (abort) abort_seq();
      else run_ack(kind, vb, tdata, nmi_at);
    end
  endtask

  initial begin
    logic [7:0] vb;
    model_reset();
    repeat (3) @(negedge Clk);
    check_reset_outputs();
    notReset = 1'b1;
    gap(2);

    // IM1: EI boundary is shadowed, next boundary takes INT.
    instr(0, 0, 0, 1, 2'd1, 0, 0, 8'h00, 16'h0000, 0, 0);
    instr(1, 0, 0, 0, 2'd0, 1, 0, 8'h00, 16'h0000, 0, 0);
    instr(0, 0, 0, 0, 2'd0, 1, 0, 8'h5A, 16'h0000, 0, 0);
    // INT low at the boundary: nothing taken.
    instr(1, 0, 0, 0, 2'd0, 0, 0, 8'h00, 16'h0000, 0, 0);
    instr(0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 16'h0000, 0, 0);
    // IM2 table read.
    I_Reg = 8'h80;
    instr(0, 0, 0, 1, 2'd2, 0, 0, 8'h00, 16'h0000, 0, 0);
    instr(0, 0, 0, 0, 2'd0, 1, 0, 8'h13, 16'h1234, 0, 0);
    // NMI beats INT, then RETN restores IFF1.
    instr(1, 0, 0, 0, 2'd0, 0, 0, 8'h00, 16'h0000, 0, 0);
    instr(0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 16'h0000, 0, 0);
    set_nmi(1);
    instr(0, 0, 0, 0, 2'd0, 1, 0, 8'h00, 16'h0000, 0, 0);
    set_nmi(0);
    instr(0, 0, 1, 0, 2'd0, 0, 0, 8'h00, 16'h0000, 0, 0);
    // NMI held high over three boundaries: one sequence only.
    gap(1);
    set_nmi(1);
    repeat (3) instr(0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 16'h0000, 0, 0);
    set_nmi(0);
    // NMI edge during an INT sequence is taken at the next boundary.
    gap(1);
    instr(1, 0, 0, 0, 2'd0, 0, 0, 8'h00, 16'h0000, 0, 0);
    instr(0, 0, 0, 0, 2'd0, 1, 0, 8'h22, 16'hBEEF, 3, 0);
    instr(0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 16'h0000, 0, 0);
    set_nmi(0);
    // IM0 with RST byte out of HALT, then a non-RST byte.
    instr(1, 0, 0, 1, 2'd0, 0, 0, 8'h00, 16'h0000, 0, 0);
    instr(0, 0, 0, 0, 2'd0, 1, 1, 8'hEF, 16'h0000, 0, 0);
    instr(1, 0, 0, 0, 2'd0, 0, 0, 8'h00, 16'h0000, 0, 0);
    instr(0, 0, 0, 0, 2'd0, 1, 0, 8'h00, 16'h0000, 0, 0);
    // IM_Sel=3 behaves as IM0; EI together with DI leaves interrupts off.
    instr(1, 1, 0, 1, 2'd3, 1, 0, 8'h00, 16'h0000, 0, 0);
    instr(0, 0, 0, 0, 2'd0, 1, 0, 8'h00, 16'h0000, 0, 0);
    // Reset in PUSH aborts; INT stays blocked until EI.
    instr(1, 0, 0, 1, 2'd1, 0, 0, 8'h00, 16'h0000, 0, 0);
    instr(0, 0, 0, 0, 2'd0, 1, 0, 8'h00, 16'h0000, 0, 1);
    instr(0, 0, 0, 0, 2'd0, 1, 0, 8'h00, 16'h0000, 0, 0);
    instr(1, 0, 0, 0, 2'd0, 1, 0, 8'h00, 16'h0000, 0, 0);
    instr(0, 0, 0, 0, 2'd0, 1, 0, 8'h00, 16'h0000, 0, 0);

    // Random instruction stream.
    for (int i = 0; i < 150; i++) begin
      I_Reg = 8'($urandom);
      if ($urandom_range(0, 9) == 0) set_nmi(!NMI);
      gap(int'($urandom_range(0, 2)));
      vb = ($urandom_range(0, 1) == 1) ? {2'b11, 3'($urandom), 3'b111} : 8'($urandom);
      instr($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0, 2'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, vb, 16'($urandom),
            ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
